// File: rtl/inv_factorial_blk.sv
// Inverse factorial: finds the largest n (0..MAX_N) with n! <= in_data by repeated
// multiplication, and flags an exact match. One multiply step per clock while busy.
module inv_factorial_blk #(
   parameter int unsigned DATA_W = 46,
   parameter int unsigned MAX_N  = 15,
   localparam int unsigned NW    = $clog2(MAX_N + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic [NW-1:0]     out_data,
   output logic              out_exact,
   output logic              out_valid,
   output logic              out_busy
);

   localparam int unsigned XW = DATA_W + 4;

   typedef enum logic {IDLE, CALC} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   target_q, target_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [NW-1:0]       n_q, n_d;
   logic [NW-1:0]       out_data_q, out_data_d;
   logic                out_exact_q, out_exact_d;
   logic                out_valid_q, out_valid_d;
   logic [XW-1:0]       nxt;
   logic                finish;

   // Product kept wide so an overshoot past target is seen before it could wrap.
   assign nxt    = XW'(acc_q) * (XW'(n_q) + XW'(1));
   assign finish = (n_q == NW'(MAX_N)) || (nxt > XW'(target_q));

   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      acc_d       = acc_q;
      n_d         = n_q;
      out_data_d  = out_data_q;
      out_exact_d = out_exact_q;
      out_valid_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               target_d = in_data;
               acc_d    = DATA_W'(1);
               n_d      = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            if (finish) begin
               out_data_d  = n_q;
               out_exact_d = (acc_q == target_q);
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               acc_d = nxt[DATA_W-1:0];
               n_d   = n_q + NW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         target_q    <= '0;
         acc_q       <= '0;
         n_q         <= '0;
         out_data_q  <= '0;
         out_exact_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         target_q    <= target_d;
         acc_q       <= acc_d;
         n_q         <= n_d;
         out_data_q  <= out_data_d;
         out_exact_q <= out_exact_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_exact = out_exact_q;
   assign out_valid = out_valid_q;
   assign out_busy  = (state_q == CALC);

endmodule

// File: tb/tb_inv_factorial_blk.sv
// Bench for inv_factorial_blk: vector table plus hand sequences, results checked
// against a queue of expected {n, exact} pushed at each accept.
module tb_inv_factorial_blk;

   localparam int unsigned DATA_W = 46;

   typedef struct {
      logic [DATA_W-1:0] value;
      logic [3:0]        exp_n;
      logic              exp_exact;
   } vec_t;

   typedef struct {
      logic [3:0] n;
      logic       exact;
   } res_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic [3:0]        out_data;
   logic              out_exact;
   logic              out_valid;
   logic              out_busy;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned n_pushed = 0;
   int unsigned n_valid  = 0;
   res_t        sb[$];
   vec_t        vecs[$];

   inv_factorial_blk #(.DATA_W(DATA_W), .MAX_N(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .out_data  (out_data),
      .out_exact (out_exact),
      .out_valid (out_valid),
      .out_busy  (out_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic logic [DATA_W-1:0] fact(input int unsigned k);
      logic [DATA_W-1:0] f = 1;
      for (int unsigned i = 2; i <= k; i++) f = f * DATA_W'(i);
      return f;
   endfunction

   // Scoreboard side: every out_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         res_t r;
         n_valid++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got n=%0d with nothing pending", out_data);
         end else begin
            r = sb.pop_front();
            check("result_n", 64'(out_data), 64'(r.n));
            check("result_exact", 64'(out_exact), 64'(r.exact));
         end
      end
   end

   task automatic push(input logic [3:0] n, input logic exact);
      res_t r;
      r.n = n;
      r.exact = exact;
      sb.push_back(r);
      n_pushed++;
   endtask

   task automatic wait_not_busy();
      int unsigned k = 0;
      while (out_busy && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      if (out_busy) check("busy_timeout", 64'(out_busy), 64'd0);
   endtask

   task automatic wait_drain();
      int unsigned k = 0;
      while ((sb.size() != 0 || out_busy) && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   // Leaves the caller 1 time unit after the accept edge.
   task automatic send(input logic [DATA_W-1:0] v, input logic [3:0] en, input logic ex);
      wait_not_busy();
      in_data  = v;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      push(en, ex);
   endtask

   initial begin
      int unsigned lat;
      reset    = 1'b1;
      in_data  = '0;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_data", 64'(out_data), 64'd0);
      check("reset_exact", 64'(out_exact), 64'd0);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_busy", 64'(out_busy), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // T1: result latency for 6 -> 3
      in_data  = 46'd6;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      push(4'd3, 1'b1);
      check("t1_busy_after_accept", 64'(out_busy), 64'd1);
      lat = 0;
      for (int unsigned k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      check("t1_latency_edges", 64'(lat), 64'd4);
      check("t1_busy_on_valid", 64'(out_busy), 64'd0);
      wait_drain();

      // T2/T3 vector table
      vecs.push_back('{46'd120, 4'd5, 1'b1});
      vecs.push_back('{46'd100, 4'd4, 1'b0});
      vecs.push_back('{46'd0, 4'd0, 1'b0});
      vecs.push_back('{46'd1, 4'd1, 1'b1});
      vecs.push_back('{46'd2, 4'd2, 1'b1});
      vecs.push_back('{46'd23, 4'd3, 1'b0});
      vecs.push_back('{46'd1307674368000, 4'd15, 1'b1});
      vecs.push_back('{46'd1307674367999, 4'd14, 1'b0});
      vecs.push_back('{46'h3FFF_FFFF_FFFF, 4'd15, 1'b0});
      foreach (vecs[i]) send(vecs[i].value, vecs[i].exp_n, vecs[i].exp_exact);
      wait_drain();

      // T4: in_valid held while busy must be ignored
      send(46'd720, 4'd6, 1'b1);
      in_data  = 46'd24;
      in_valid = 1'b1;
      for (int unsigned k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("t4_busy_hold", 64'(out_busy), 64'd1);
      end
      in_valid = 1'b0;
      wait_drain();
      repeat (3) @(posedge clk);
      #1;
      check("t4_idle_after", 64'(out_busy), 64'd0);

      // T5: reset aborts a running job
      send(46'd5040, 4'd0, 1'b0);
      void'(sb.pop_back());
      n_pushed--;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("t5_data", 64'(out_data), 64'd0);
      check("t5_exact", 64'(out_exact), 64'd0);
      check("t5_valid", 64'(out_valid), 64'd0);
      check("t5_busy", 64'(out_busy), 64'd0);
      repeat (12) @(posedge clk);
      #1;
      send(46'd2, 4'd2, 1'b1);
      wait_drain();

      // T6: loopback of k! back-to-back with in_valid held
      in_valid = 1'b1;
      for (int unsigned k = 0; k <= 15; k++) begin
         in_data = fact(k);
         wait_not_busy();
         @(posedge clk); #1;
         push((k == 0) ? 4'd1 : 4'(k), 1'b1);
         check("t6_accepted", 64'(out_busy), 64'd1);
      end
      in_valid = 1'b0;
      wait_drain();

      check("pulse_count", 64'(n_valid), 64'(n_pushed));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time limit reached");
      $fatal(1);
   end

endmodule
